// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    localparam int unsigned CNT_W = 16;

    // Bit width needed to hold values 0..v-1; never less than 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        while (r < 31 && (32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first requester with req high, scanning upward from last+1 with wrap.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [clog2(N_REQ)-1:0] last,
    output logic [N_REQ-1:0]        pick,
    output logic [clog2(N_REQ)-1:0] pick_idx
);

    localparam int unsigned OW = clog2(N_REQ);

    logic          found;
    logic [OW-1:0] idx;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        idx      = '0;
        // Modulo wrap keeps non-power-of-2 N_REQ inside 0..N_REQ-1.
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = OW'((32'(last) + k) % N_REQ);
            if (!found && req[idx]) begin
                found         = 1'b1;
                pick[idx]     = 1'b1;
                pick_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-granted arbiter sharing the async FIFO write port among N_REQ requesters.
// Define FIFO_WR_ARB_STATS_EN to enable the per-requester saturating word counters on word_cnt.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned d_width   = 8,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                     wclk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*d_width-1:0] req_data,
    input  logic                     full,
    output logic [N_REQ-1:0]         gnt,
    output logic [clog2(N_REQ)-1:0]  owner,
    output logic                     busy,
    output logic                     w_en,
    output logic [d_width-1:0]       wr_data,
    output logic [N_REQ*CNT_W-1:0]   word_cnt
);

    localparam int unsigned OW = clog2(N_REQ);
    localparam int unsigned CW = clog2(BURST_LEN + 1);

    arb_state_e    state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_q, last_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic [N_REQ-1:0] pick_oh;
    logic [OW-1:0]    pick_idx;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req      (req),
        .last     (last_q),
        .pick     (pick_oh),
        .pick_idx (pick_idx)
    );

    // Next-state and write-port drive; grant is combinational from owner, req and full.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        gnt         = '0;
        w_en        = 1'b0;
        wr_data     = '0;
        case (state_q)
            ARB_IDLE: begin
                if (|pick_oh) begin
                    owner_d     = pick_idx;
                    burst_cnt_d = '0;
                    state_d     = ARB_BURST;
                end
            end
            ARB_BURST: begin
                wr_data      = req_data[32'(owner_q)*d_width +: d_width];
                w_en         = req[owner_q] & ~full;
                gnt[owner_q] = w_en;
                if (!req[owner_q]) begin
                    state_d = ARB_IDLE;
                    last_d  = owner_q;
                end else if (w_en) begin
                    if (burst_cnt_q == CW'(BURST_LEN - 1)) begin
                        state_d = ARB_IDLE;
                        last_d  = owner_q;
                    end else begin
                        burst_cnt_d = burst_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= '0;
            last_q      <= OW'(N_REQ - 1);
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign owner = owner_q;
    assign busy  = (state_q == ARB_BURST);

`ifdef FIFO_WR_ARB_STATS_EN
    logic [CNT_W-1:0] word_cnt_q [N_REQ];
    logic [CNT_W-1:0] word_cnt_d [N_REQ];

    // Saturating per-requester accepted-word counters.
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            word_cnt_d[i] = word_cnt_q[i];
            if (gnt[i] && (word_cnt_q[i] != {CNT_W{1'b1}})) begin
                word_cnt_d[i] = word_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge wclk) begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (reset) begin
                word_cnt_q[i] <= '0;
            end else begin
                word_cnt_q[i] <= word_cnt_d[i];
            end
        end
    end

    always_comb begin
        word_cnt = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            word_cnt[i*CNT_W +: CNT_W] = word_cnt_q[i];
        end
    end
`else
    assign word_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester model drives stimulus, a scoreboard checks each write.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned BL = 4;
`ifdef FIFO_WR_ARB_STATS_EN
    localparam int STATS_EXP = 10;
`else
    localparam int STATS_EXP = 0;
`endif

    logic            wclk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic            full;
    logic [N-1:0]    gnt;
    logic [1:0]      owner;
    logic            busy;
    logic            w_en;
    logic [DW-1:0]   wr_data;
    logic [N*CNT_W-1:0] word_cnt;

    fifo_wr_arbiter #(.N_REQ(N), .d_width(DW), .BURST_LEN(BL)) dut (
        .wclk     (wclk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .full     (full),
        .gnt      (gnt),
        .owner    (owner),
        .busy     (busy),
        .w_en     (w_en),
        .wr_data  (wr_data),
        .word_cnt (word_cnt)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        int idx;
        int k;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         rem[N];
    int         nxt[N];
    logic [N-1:0] gs;
    logic       ws;
    logic [63:0] tr;

    function automatic logic [DW-1:0] word(input int i, input int k);
        return DW'(i * 16 + k);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_tests++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req_v);
        end
    endtask

    task automatic push(input int i, input int k);
        exp_t e;
        e.idx = i;
        e.k   = k;
        exp_q.push_back(e);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i] = (rem[i] > 0);
            req_data[i*DW +: DW] = word(i, nxt[i]);
        end
    endtask

    // One clock: sample grant at negedge, then advance the requester model after the edge.
    task automatic cycle();
        @(negedge wclk);
        gs = gnt;
        ws = w_en;
        @(posedge wclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (gs[i]) begin
                rem[i]--;
                nxt[i]++;
            end
        end
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic run_trace(input int n);
        tr = '0;
        for (int c = 0; c < n; c++) begin
            cycle();
            tr[c] = ws;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        full  = 1'b0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            nxt[i] = 0;
        end
        drive();
        cycle();
        reset = 1'b0;
    endtask

    // Scoreboard monitor: every write must match the next expected word.
    always @(negedge wclk) begin
        if (w_en === 1'b1) begin
            check("w_en_while_full", 32'(full), 32'(0));
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: gnt=%b data=0x%0h, required no write", gnt, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_gnt", 32'(gnt), 32'(1 << mon_e.idx));
                check("sb_data", 32'(wr_data), 32'(word(mon_e.idx, mon_e.k)));
            end
        end
    end

    initial begin
        reset    = 1'b1;
        full     = 1'b0;
        req      = '0;
        req_data = '0;

        // Reset state
        apply_reset();
        check("rst_owner", 32'(owner), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_w_en", 32'(w_en), 32'(0));
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_wr_data", 32'(wr_data), 32'(0));
        check("rst_word_cnt", 32'(word_cnt != '0), 32'(0));

        // Single requester, 6 words: 4-word burst, one idle cycle, then 2 words
        apply_reset();
        rem[0] = 6;
        drive();
        for (int k = 0; k < 6; k++) push(0, k);
        run_trace(10);
        check("t1_wen_trace", 32'(tr[9:0]), 32'(10'b0011011110));
        check("t1_drained", 32'(exp_q.size()), 32'(0));

        // All requesters, 10 words each: two full rounds then 2-word tails
        apply_reset();
        for (int i = 0; i < N; i++) rem[i] = 10;
        drive();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++)
                for (int k = 0; k < 4; k++) push(i, r * 4 + k);
        for (int i = 0; i < N; i++)
            for (int k = 8; k < 10; k++) push(i, k);
        run(70);
        check("t2_drained", 32'(exp_q.size()), 32'(0));
        check("t2_owner_last", 32'(owner), 32'(3));
        check("t2_busy_end", 32'(busy), 32'(0));
        for (int i = 0; i < N; i++)
            check("t2_word_cnt", 32'(word_cnt[i*CNT_W +: CNT_W]), 32'(STATS_EXP));

        // Full stall mid-burst on owner 2
        apply_reset();
        rem[2] = 4;
        drive();
        for (int k = 0; k < 4; k++) push(2, k);
        for (int c = 0; c < 10 && nxt[2] < 2; c++) cycle();
        check("t3_two_words", 32'(nxt[2]), 32'(2));
        full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            check("t3_stall_wen", 32'(ws), 32'(0));
            check("t3_stall_gnt", 32'(gs), 32'(0));
        end
        check("t3_owner_held", 32'(owner), 32'(2));
        check("t3_busy_held", 32'(busy), 32'(1));
        full = 1'b0;
        run(8);
        check("t3_drained", 32'(exp_q.size()), 32'(0));
        check("t3_busy_end", 32'(busy), 32'(0));

        // Early release by requester 1, then round-robin resumes at 2
        apply_reset();
        rem[1] = 2;
        drive();
        push(1, 0);
        push(1, 1);
        run(6);
        check("t4_released_idle", 32'(busy), 32'(0));
        rem[1] = 1;
        rem[2] = 1;
        drive();
        push(2, 0);
        push(1, 2);
        cycle();
        check("t4_next_owner", 32'(owner), 32'(2));
        check("t4_busy", 32'(busy), 32'(1));
        run(10);
        check("t4_drained", 32'(exp_q.size()), 32'(0));

        // Reset during owner 3's second word
        apply_reset();
        rem[3] = 4;
        drive();
        push(3, 0);
        push(3, 1);
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        check("t5_second_word", 32'(ws), 32'(1));
        reset = 1'b0;
        rem[0] = 1;
        drive();
        check("t5_owner_rst", 32'(owner), 32'(0));
        check("t5_busy_rst", 32'(busy), 32'(0));
        push(0, 0);
        push(3, 2);
        push(3, 3);
        cycle();
        check("t5_no_wen", 32'(ws), 32'(0));
        check("t5_pick_from_0", 32'(owner), 32'(0));
        run(10);
        check("t5_drained", 32'(exp_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Write-side arbiter for the async FIFO, clocked entirely in the write domain.
- Shares the single FIFO write port (wr_data/w_en) between N_REQ requesters using round-robin, burst-granted arbitration.
- Honours the FIFO full flag, so no write is issued while full is high.
- Sits directly in front of the async FIFO write interface; the read side is untouched.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- d_width, 8, data word width; matches the FIFO.
- BURST_LEN, 4, maximum accepted words per grant before priority rotates (1..16).

Ports:
- wclk  input  1  write-domain clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester request; the word on req_data is valid while high.
- req_data  input  N_REQ*d_width  flat data bus; requester i occupies bits [i*d_width +: d_width].
- full  input  1  FIFO full flag (write domain).
- gnt  output  N_REQ  one-hot; high in the cycle requester i's word is written.
- owner  output  clog2(N_REQ)  index of the current burst owner.
- busy  output  1  high while in BURST.
- w_en  output  1  FIFO write enable.
- wr_data  output  d_width  FIFO write data.
- word_cnt  output  N_REQ*16  per-requester accepted-word counters (see Optional Feature).

Behaviour:
- Reset state (synchronous, sampled on rising wclk):
  - state=IDLE, owner=0, last=N_REQ-1, burst_cnt=0.
  - gnt=0, w_en=0, busy=0, wr_data=0, word_cnt=0.
- States: IDLE and BURST.
- IDLE:
  - If any req is high, pick the first requester with req high scanning from last+1 upward, with wrap-around.
  - Load owner with the pick, clear burst_cnt, and go to BURST next cycle.
  - Arbitration latency is 1 cycle. No transfer happens in IDLE.
- BURST, accept condition: accept = req[owner] & ~full.
  - w_en = accept and gnt = accept<<owner. Both are combinational from registered state, req and full.
  - wr_data = req_data slice of owner, driven every BURST cycle; 0 in IDLE.
  - On accept, burst_cnt increments.
- BURST exit: leave to IDLE and set last=owner when either:
  - accept occurs and burst_cnt==BURST_LEN-1 (burst complete), or
  - req[owner]==0 (requester released, no transfer that cycle).
- full high in BURST:
  - No accept and no counter advance; the owner is held.
  - Requester data must stay stable (standard valid-hold rule).
- Requester handshake:
  - A requester must keep req and its data stable until it sees gnt.
  - It may drop req only after a grant or before being selected.
- req changes on non-owners during BURST are ignored until the next IDLE.
- Maximum wait: any continuously requesting requester is granted within (N_REQ-1)*(BURST_LEN+1)+1 cycles, excluding full stalls.
- Reset asserted mid-burst: the next edge returns to reset state and the partial burst is discarded with no further w_en. Words already written stay in the FIFO.
- Width rules:
  - burst_cnt is clog2(BURST_LEN+1) bits.
  - owner/last wrap modulo N_REQ; for non-power-of-2 N_REQ, wrap explicitly at N_REQ-1.

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- Defined:
  - word_cnt[i*16 +: 16] increments on each gnt[i].
  - Counters saturate at 16'hFFFF and clear only on reset.
- Undefined: the word_cnt port stays present and is tied to 0; no counter flops are synthesised.

Decomposition:
- Package fifo_arb_pkg holds:
  - state typedef (ARB_IDLE, ARB_BURST);
  - CNT_W=16;
  - a clog2 helper function.
- One natural sub-module, rr_pick: combinational round-robin picker with inputs req and last, and outputs a one-hot pick plus its index.
- fifo_wr_arbiter instantiates rr_pick once.

Test Plan:
- Single requester: req=4'b0001 with 6 words, full=0. Expect first w_en at cycle 2 after req. Words 0-3 go back-to-back, then 1 IDLE cycle, then words 4-5. gnt=0001 on each.
- All requesters: req=4'b1111 continuous, full=0. Expect grant order 0,1,2,3,0, each burst exactly 4 words, with 1 idle cycle between bursts.
- Full stall: owner=2, mid-burst after 2 words, full=1 for 5 cycles. Expect w_en=0 and gnt=0 throughout. Then 2 more words, burst ends, and no extra writes occur.
- Early release: requester 1 drops req after 2 grants. Expect exit to IDLE and last=1; the next pick is 2 when req=4'b0110.
- Reset mid-burst: reset=1 for one cycle during owner=3's 2nd word. Expect w_en=0 next cycle, owner=0, busy=0, and the next arbitration starting from requester 0.
- Stats (FIFO_WR_ARB_STATS_EN): after the all-requesters test runs 40 words, expect word_cnt=10 per requester. Forcing a counter to 16'hFFFF and granting holds it at 16'hFFFF.
